urx_cmd_ctrl: RTL
=================

Name: urx_cmd_ctrl

Overview:
- Command-frame controller on the output of the UART receive PHY (rx_data/rx_vld at 115200 baud, clk_sys = 100 MHz).
- Sequences received bytes through a fixed 6-byte frame, checks the checksum and enforces an inter-byte timeout from pluse_us.
- Presents each good command to the register/control fabric over a valid/ready handshake.
- Reports checksum, timeout and overrun errors.

Parameters:
- HEAD, 8'hAA, frame header byte.
- TIMEOUT_US, 2000, maximum gap in pluse_us ticks between bytes inside a frame (range 1..4095).

Ports:
- clk_sys  input  1  system clock, 100 MHz
- rst  input  1  synchronous reset, active-high
- pluse_us  input  1  one-clk_sys pulse every 1 us
- rx_data  input  8  received byte from the UART RX PHY
- rx_vld  input  1  one-cycle strobe, rx_data valid
- cmd_op  output  8  command opcode
- cmd_addr  output  8  register address
- cmd_data  output  16  write data, {data_hi, data_lo}
- cmd_vld  output  1  command pending; held until accepted
- cmd_rdy  input  1  downstream accepts the command when cmd_vld & cmd_rdy
- err_vld  output  1  one-cycle error strobe
- err_code  output  2  1 = checksum, 2 = timeout, 3 = overrun; holds last value
- err_cnt  output  8  saturating error count
- busy  output  1  high whenever state != S_IDLE

Behaviour:
- Interface: one clock, clk_sys. rst is synchronous and active-high. All outputs are registered.
- Reset: state S_IDLE; all outputs 0; timeout counter 0.
- Frame format: HEAD, OP, ADDR, DHI, DLO, SUM. SUM = (OP+ADDR+DHI+DLO) mod 256.
- FSM states: S_IDLE, S_OP, S_ADDR, S_DHI, S_DLO, S_SUM. Transitions occur only on rx_vld.
  - S_IDLE: on rx_data == HEAD go to S_OP. Any other byte is ignored silently, with no error.
  - S_OP -> S_ADDR -> S_DHI -> S_DLO -> S_SUM: each state latches its byte into a shadow register and adds it into an 8-bit running sum. The sum is cleared on entry to S_OP.
  - S_SUM, on rx_vld: go to S_IDLE. If rx_data == running sum the frame is good; otherwise it is a checksum error.
- HEAD inside a frame is treated as data; there is no resynchronisation.
- Good frame, next cycle:
  - If cmd_vld == 0, or cmd_vld & cmd_rdy in the same cycle: load cmd_op/addr/data from the shadow registers and set cmd_vld = 1. Latency is 1 clk_sys from the SUM byte's rx_vld to cmd_vld.
  - Otherwise the frame is dropped, the pending command is unchanged, and err_code = 3.
- cmd_vld clears on cmd_vld & cmd_rdy unless a new command loads in that same cycle. cmd_op/addr/data stay stable while cmd_vld is high.
- Timeout:
  - 12-bit counter, active in every state except S_IDLE.
  - Cleared on any rx_vld and on entry to S_IDLE; otherwise increments on pluse_us.
  - When it reaches TIMEOUT_US: go to S_IDLE, err_code = 2, discard the partial frame.
  - If rx_vld and the terminal count occur in the same cycle, rx_vld wins: the byte is processed and the counter is cleared.
- Errors: err_vld pulses for 1 cycle with err_code updated; err_cnt increments and saturates at 8'hFF. Only one error can occur per cycle, since completion and timeout are mutually exclusive by the priority rule above.
- rst asserted mid-frame or with a pending command returns everything to reset values. The partial frame and the pending command are lost, with no error report.
- rx_vld is single-cycle and bytes are ≥ 8600 cycles apart; no byte buffering is required.

Decomposition:
- Shared package urx_pkg holds:
  - state encodings S_IDLE..S_SUM (3-bit);
  - error codes ERR_NONE = 0, ERR_SUM = 1, ERR_TMO = 2, ERR_OVR = 3;
  - the default header 8'hAA.
- One sub-module: urx_tmo_cnt, the pluse_us timeout counter with clear, enable and terminal-count output, reusable by the TX side.
- The FSM, shadow registers and handshake stay in urx_cmd_ctrl.

Test Plan:
- Good frame: send bytes AA 01 10 12 34 57, cmd_rdy = 1 -> cmd_vld for 1 cycle with op 01, addr 10, data 1234; err_cnt = 0.
- Bad checksum: send AA 01 10 12 34 58 -> no cmd_vld; err_vld pulse, err_code = 1, err_cnt = 1.
- Timeout:
  - send AA 01, then stop for 2000 pluse_us ticks -> err_code = 2, busy falls, and the next AA starts a clean frame;
  - send a byte at exactly tick 2000 -> no timeout.
- Overrun: cmd_rdy = 0, send two good frames -> first command held stable, second dropped, err_code = 3. Raise cmd_rdy in the completion cycle of the second frame -> second command loads, no error.
- Idle junk: send 55 00 FF AA 02 20 00 01 23 -> the first three bytes are ignored, then cmd op 02, addr 20, data 0001.
- Reset mid-frame: assert rst after AA 01 10 -> outputs 0, state S_IDLE. A following complete frame decodes correctly.

Source files
------------

// File: rtl/urx_pkg.sv
// Shared definitions for the UART RX command path: FSM state encodings,
// error codes and the default frame header.
package urx_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP   = 3'd1,
    S_ADDR = 3'd2,
    S_DHI  = 3'd3,
    S_DLO  = 3'd4,
    S_SUM  = 3'd5
  } urx_state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_SUM  = 2'd1,
    ERR_TMO  = 2'd2,
    ERR_OVR  = 2'd3
  } urx_err_e;

  localparam logic [7:0] URX_HEAD  = 8'hAA;
  localparam int         URX_TMO_W = 12;

endpackage

// File: rtl/urx_tmo_cnt.sv
// Inter-byte timeout counter: counts tick pulses while enabled, clears on clr,
// and flags the terminal count once LIMIT ticks have elapsed.
module urx_tmo_cnt #(
  parameter int W     = 12,
  parameter int LIMIT = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == W'(LIMIT));

  // Parks at the terminal count so it can never wrap back below it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && tick && !tc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/urx_cmd_ctrl.sv
// UART RX command-frame controller: collects HEAD/OP/ADDR/DHI/DLO/SUM frames,
// checks the checksum and inter-byte timeout, and hands good commands downstream.
module urx_cmd_ctrl
  import urx_pkg::*;
#(
  parameter logic [7:0] HEAD       = URX_HEAD,
  parameter int         TIMEOUT_US = 2000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        pluse_us,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        cmd_vld,
  input  logic        cmd_rdy,
  output logic        err_vld,
  output logic [1:0]  err_code,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  urx_state_e  state_q, state_d;
  logic [7:0]  op_q, op_d, addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  cmd_op_q, cmd_op_d, cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_data_q, cmd_data_d;
  logic        cmd_vld_q, cmd_vld_d;
  logic        err_vld_q, err_vld_d;
  urx_err_e    err_code_q, err_code_d, err_sel;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        err_hit;
  logic        tmo_tc, tmo_en, tmo_clr, tmo_hit;
  logic        frame_done, frame_good;

  // A byte arriving on the terminal-count cycle wins over the timeout.
  assign tmo_en     = (state_q != S_IDLE);
  assign tmo_hit    = tmo_en && tmo_tc && !rx_vld;
  assign tmo_clr    = rx_vld || (state_d == S_IDLE);
  assign frame_done = rx_vld && (state_q == S_SUM);
  assign frame_good = frame_done && (rx_data == sum_q);

  urx_tmo_cnt #(
    .W     (URX_TMO_W),
    .LIMIT (TIMEOUT_US)
  ) u_tmo_cnt (
    .clk  (clk_sys),
    .rst  (rst),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .tick (pluse_us),
    .tc   (tmo_tc)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_vld) begin
      case (state_q)
        S_IDLE:  if (rx_data == HEAD) state_d = S_OP;
        S_OP:    state_d = S_ADDR;
        S_ADDR:  state_d = S_DHI;
        S_DHI:   state_d = S_DLO;
        S_DLO:   state_d = S_SUM;
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    op_d       = op_q;
    addr_d     = addr_q;
    dhi_d      = dhi_q;
    dlo_d      = dlo_q;
    sum_d      = sum_q;
    cmd_op_d   = cmd_op_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    cmd_vld_d  = cmd_vld_q;
    err_code_d = err_code_q;
    err_cnt_d  = err_cnt_q;
    err_hit    = 1'b0;
    err_sel    = ERR_NONE;

    if (rx_vld) begin
      case (state_q)
        S_IDLE:  if (rx_data == HEAD) sum_d = '0;
        S_OP:    begin op_d   = rx_data; sum_d = sum_q + rx_data; end
        S_ADDR:  begin addr_d = rx_data; sum_d = sum_q + rx_data; end
        S_DHI:   begin dhi_d  = rx_data; sum_d = sum_q + rx_data; end
        S_DLO:   begin dlo_d  = rx_data; sum_d = sum_q + rx_data; end
        default: ;
      endcase
    end

    if (cmd_vld_q && cmd_rdy) begin
      cmd_vld_d = 1'b0;
    end

    // A good frame only loads if the slot is free or being emptied this cycle.
    if (frame_good) begin
      if (!cmd_vld_q || cmd_rdy) begin
        cmd_op_d   = op_q;
        cmd_addr_d = addr_q;
        cmd_data_d = {dhi_q, dlo_q};
        cmd_vld_d  = 1'b1;
      end else begin
        err_hit = 1'b1;
        err_sel = ERR_OVR;
      end
    end else if (frame_done) begin
      err_hit = 1'b1;
      err_sel = ERR_SUM;
    end else if (tmo_hit) begin
      err_hit = 1'b1;
      err_sel = ERR_TMO;
    end

    err_vld_d = err_hit;
    if (err_hit) begin
      err_code_d = err_sel;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      op_q       <= '0;
      addr_q     <= '0;
      dhi_q      <= '0;
      dlo_q      <= '0;
      sum_q      <= '0;
      cmd_op_q   <= '0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      cmd_vld_q  <= 1'b0;
      err_vld_q  <= 1'b0;
      err_code_q <= ERR_NONE;
      err_cnt_q  <= '0;
    end else begin
      op_q       <= op_d;
      addr_q     <= addr_d;
      dhi_q      <= dhi_d;
      dlo_q      <= dlo_d;
      sum_q      <= sum_d;
      cmd_op_q   <= cmd_op_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      cmd_vld_q  <= cmd_vld_d;
      err_vld_q  <= err_vld_d;
      err_code_q <= err_code_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign cmd_op   = cmd_op_q;
  assign cmd_addr = cmd_addr_q;
  assign cmd_data = cmd_data_q;
  assign cmd_vld  = cmd_vld_q;
  assign err_vld  = err_vld_q;
  assign err_code = err_code_q;
  assign err_cnt  = err_cnt_q;
  assign busy     = (state_q != S_IDLE);

endmodule
